afc_cal_sequencer: RTL and testbench
====================================

AFC_CAL_SEQUENCER -- requirements
Module: afc_cal_sequencer

Interface
REQ-001 Parameter CNT_W, default 12: width of the edge counter, target and tolerance.
REQ-002 Parameter SETTLE_CYC, default 16: clk cycles waited after each band step before measuring.
REQ-003 Parameter MAX_STEPS, default 6: comparison issues allowed before failure.
REQ-004 Port clk  in  1  system/reference clock.
REQ-005 Port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 Port start  in  1  single-cycle request to begin a calibration run.
REQ-007 Port abort  in  1  level; terminates any run.
REQ-008 Port vco_edge  in  1  single-cycle pulse per divided-VCO edge, already synchronized to clk.
REQ-009 Port window_len  in  16  measurement window length in clk cycles.
REQ-010 Port target_cnt  in  CNT_W  expected edge count per window.
REQ-011 Port tol  in  CNT_W  allowed +/- deviation from target_cnt.
REQ-012 Port comp_out  out  3  comparison code to search FSM: FAST=100, SLOW=010, FREEZE=001, idle=000.
REQ-013 Port comp_valid  out  1  single-cycle strobe qualifying comp_out (drives the search FSM done input).
REQ-014 Port busy  out  1  high while a run is in progress.
REQ-015 Port cal_done  out  1  sticky; run ended with FREEZE.
REQ-016 Port cal_fail  out  1  sticky; run ended without FREEZE after MAX_STEPS.

Function
REQ-017 States: IDLE, SETTLE, MEASURE, COMPARE, DONE, FAIL; one state register.
REQ-018 IDLE: start=1 clears cal_done/cal_fail and step counter, enters SETTLE next cycle; busy=1 from that cycle.
REQ-019 SETTLE: counts SETTLE_CYC cycles (SETTLE_CYC=0 -> one cycle), then MEASURE with edge counter cleared.
REQ-020 MEASURE: lasts exactly max(window_len,1) cycles; each vco_edge increments counter, including an edge in the final cycle.
REQ-021 Edge counter saturates at 2^CNT_W-1; no wrap.
REQ-022 window_len, target_cnt and tol are sampled on entry to MEASURE; changes mid-window take effect next window.
REQ-023 COMPARE (one cycle): count > target_cnt+tol -> FAST; count < target_cnt-tol -> SLOW; otherwise FREEZE.
REQ-024 Bounds computed at CNT_W+1 bits; lower bound saturates at 0, upper bound never wraps.
REQ-025 In COMPARE, comp_valid=1 for exactly one cycle with comp_out set; comp_out returns to 000 next cycle.
REQ-026 FREEZE -> DONE; FAST/SLOW increments step counter; if new count = MAX_STEPS -> FAIL, else SETTLE.
REQ-027 DONE sets cal_done, FAIL sets cal_fail; both drop busy and return to IDLE next cycle; flags hold until next start or reset.
REQ-028 start while busy is ignored.
REQ-029 abort (any state, priority over start and COMPARE): IDLE next cycle, busy=0, no comp_valid, flags unchanged.
REQ-030 Latency start->first comp_valid = 1 + max(SETTLE_CYC,1) + max(window_len,1) + 1 cycles.

Reset
REQ-031 rst_n low: state=IDLE, counters=0, comp_out=000, comp_valid=0, busy=0, cal_done=0, cal_fail=0, asynchronously.
REQ-032 Reset mid-run abandons the run; no comp_valid after release until a new start.

Configuration
REQ-033 Macro AFC_SEQ_STATUS_EN defined: adds outputs last_cnt[CNT_W-1:0] (count latched in COMPARE, reset 0) and step_cnt[3:0] (current step counter).
REQ-034 Macro undefined: those ports and registers are absent; all other behaviour identical.

Verification
REQ-035 target=100, tol=2, edges=101/window -> single comp_valid with 001, cal_done=1, busy=0 after.
REQ-036 target=100, tol=2, edges 120 then 90 then 100 -> comp_out 100, 010, 001 on successive strobes; cal_done=1.
REQ-037 MAX_STEPS=6, edges always 0 -> six strobes of 010, then cal_fail=1, cal_done=0.
REQ-038 target=1, tol=5, edges=0 -> FREEZE (lower bound saturates to 0); edges continuous with CNT_W=4, target=10, tol=2 -> count saturates at 15, FAST.
REQ-039 abort asserted during MEASURE -> IDLE next cycle, no comp_valid; start pulsed while busy -> no restart, latency per REQ-030 unchanged.
REQ-040 rst_n asserted mid-SETTLE -> all outputs at reset values immediately; no strobe after release.

Source files
------------

// File: rtl/afc_cal_if.sv
// Handshake/status bundle between the AFC search controller and afc_cal_sequencer.
// AFC_SEQ_STATUS_EN adds the last_cnt/step_cnt status signals.
interface afc_cal_if #(
  parameter int unsigned CNT_W = 12
);
  logic             start;
  logic             abort;
  logic             vco_edge;
  logic [15:0]      window_len;
  logic [CNT_W-1:0] target_cnt;
  logic [CNT_W-1:0] tol;
  logic [2:0]       comp_out;
  logic             comp_valid;
  logic             busy;
  logic             cal_done;
  logic             cal_fail;
`ifdef AFC_SEQ_STATUS_EN
  logic [CNT_W-1:0] last_cnt;
  logic [3:0]       step_cnt;

  modport master (
    output start, abort, vco_edge, window_len, target_cnt, tol,
    input  comp_out, comp_valid, busy, cal_done, cal_fail, last_cnt, step_cnt
  );
  modport slave (
    input  start, abort, vco_edge, window_len, target_cnt, tol,
    output comp_out, comp_valid, busy, cal_done, cal_fail, last_cnt, step_cnt
  );
`else
  modport master (
    output start, abort, vco_edge, window_len, target_cnt, tol,
    input  comp_out, comp_valid, busy, cal_done, cal_fail
  );
  modport slave (
    input  start, abort, vco_edge, window_len, target_cnt, tol,
    output comp_out, comp_valid, busy, cal_done, cal_fail
  );
`endif
endinterface

// File: rtl/afc_cal_sequencer.sv
// AFC calibration sequencer: settle, count VCO edges over a window, compare against target.
// Define AFC_SEQ_STATUS_EN to expose last_cnt/step_cnt status outputs.
module afc_cal_sequencer #(
  parameter int unsigned CNT_W      = 12,
  parameter int unsigned SETTLE_CYC = 16,
  parameter int unsigned MAX_STEPS  = 6
) (
  input logic      clk,
  input logic      rst_n,
  afc_cal_if.slave io_bus
);
  localparam int unsigned    SetW       = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [SetW-1:0] SettleLast = (SETTLE_CYC > 1) ? SetW'(SETTLE_CYC - 1) : '0;
  localparam logic [3:0]     MaxSteps   = 4'(MAX_STEPS);
  localparam logic [2:0]     CodeFast   = 3'b100;
  localparam logic [2:0]     CodeSlow   = 3'b010;
  localparam logic [2:0]     CodeFreeze = 3'b001;

  typedef enum logic [2:0] {StIdle, StSettle, StMeasure, StCompare, StDone, StFail} state_e;

  state_e           r_state, w_state_d;
  logic [SetW-1:0]  r_settle;
  logic [15:0]      r_win_tmr, r_win_last;
  logic [CNT_W-1:0] r_edge_cnt, r_tgt, r_tol;
  logic [3:0]       r_step;
  logic [2:0]       r_comp_out;
  logic             r_comp_valid, r_cal_done, r_cal_fail;

  logic             w_settle_end, w_win_end, w_run_start, w_enter_measure, w_cmp_fire;
  logic [CNT_W:0]   w_upper, w_lower, w_cnt_ext;
  logic [2:0]       w_code;
  logic [3:0]       w_step_inc;

  assign w_settle_end = (r_settle == SettleLast);
  assign w_win_end    = (r_win_tmr == r_win_last);
  assign w_step_inc   = r_step + 4'd1;

  // One extra bit so target+tol never wraps; lower bound clamps at zero.
  assign w_cnt_ext = {1'b0, r_edge_cnt};
  assign w_upper   = {1'b0, r_tgt} + {1'b0, r_tol};
  assign w_lower   = (r_tgt >= r_tol) ? {1'b0, r_tgt - r_tol} : '0;

  always_comb begin
    w_code = CodeFreeze;
    if (w_cnt_ext > w_upper) begin
      w_code = CodeFast;
    end else if (w_cnt_ext < w_lower) begin
      w_code = CodeSlow;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d       = r_state;
    w_run_start     = 1'b0;
    w_enter_measure = 1'b0;
    w_cmp_fire      = 1'b0;
    if (io_bus.abort) begin
      w_state_d = StIdle;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (io_bus.start) begin
            w_state_d   = StSettle;
            w_run_start = 1'b1;
          end
        end
        StSettle: begin
          if (w_settle_end) begin
            w_state_d       = StMeasure;
            w_enter_measure = 1'b1;
          end
        end
        StMeasure: begin
          if (w_win_end) begin
            w_state_d = StCompare;
          end
        end
        StCompare: begin
          w_cmp_fire = 1'b1;
          if (w_code == CodeFreeze) begin
            w_state_d = StDone;
          end else if (w_step_inc == MaxSteps) begin
            w_state_d = StFail;
          end else begin
            w_state_d = StSettle;
          end
        end
        StDone, StFail: w_state_d = StIdle;
        default:        w_state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_settle     <= '0;
      r_win_tmr    <= '0;
      r_win_last   <= '0;
      r_edge_cnt   <= '0;
      r_tgt        <= '0;
      r_tol        <= '0;
      r_step       <= '0;
      r_comp_out   <= 3'b000;
      r_comp_valid <= 1'b0;
      r_cal_done   <= 1'b0;
      r_cal_fail   <= 1'b0;
    end else begin
      r_comp_valid <= w_cmp_fire;
      r_comp_out   <= w_cmp_fire ? w_code : 3'b000;

      if (w_run_start) begin
        r_cal_done <= 1'b0;
        r_cal_fail <= 1'b0;
        r_step     <= '0;
      end
      if (w_cmp_fire) begin
        if (w_code == CodeFreeze) begin
          r_cal_done <= 1'b1;
        end else begin
          r_step <= w_step_inc;
          if (w_step_inc == MaxSteps) begin
            r_cal_fail <= 1'b1;
          end
        end
      end

      if (r_state == StSettle && !w_settle_end) begin
        r_settle <= r_settle + 1'b1;
      end else begin
        r_settle <= '0;
      end

      if (r_state == StMeasure && !w_win_end) begin
        r_win_tmr <= r_win_tmr + 16'd1;
      end else begin
        r_win_tmr <= '0;
      end

      // Window parameters are frozen for the whole measurement.
      if (w_enter_measure) begin
        r_edge_cnt <= '0;
        r_win_last <= (io_bus.window_len == 16'd0) ? 16'd0 : io_bus.window_len - 16'd1;
        r_tgt      <= io_bus.target_cnt;
        r_tol      <= io_bus.tol;
      end else if (r_state == StMeasure && io_bus.vco_edge && r_edge_cnt != '1) begin
        r_edge_cnt <= r_edge_cnt + 1'b1;
      end
    end
  end

  assign io_bus.comp_out   = r_comp_out;
  assign io_bus.comp_valid = r_comp_valid;
  assign io_bus.busy       = (r_state == StSettle) || (r_state == StMeasure) ||
                             (r_state == StCompare);
  assign io_bus.cal_done   = r_cal_done;
  assign io_bus.cal_fail   = r_cal_fail;

`ifdef AFC_SEQ_STATUS_EN
  logic [CNT_W-1:0] r_last_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_cnt <= '0;
    end else if (w_cmp_fire) begin
      r_last_cnt <= r_edge_cnt;
    end
  end

  assign io_bus.last_cnt = r_last_cnt;
  assign io_bus.step_cnt = r_step;
`endif

endmodule

// File: tb/tb_afc_cal_sequencer.sv
// Scoreboard bench for afc_cal_sequencer: stimulus queues expected strobes, monitors compare.
module tb_afc_cal_sequencer;
  typedef struct {
    logic [2:0] code;
    int         lat;
    int         cnt;
  } exp_t;

  localparam logic [2:0] Fast   = 3'b100;
  localparam logic [2:0] Slow   = 3'b010;
  localparam logic [2:0] Freeze = 3'b001;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   strobes_a = 0, strobes_b = 0;
  int   start_a = 0, start_b = 0;
  logic pv_a = 1'b0, pv_b = 1'b0;
  exp_t qa[$], qb[$];
  exp_t e_a, e_b;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  afc_cal_if #(.CNT_W(12)) ifa ();
  afc_cal_if #(.CNT_W(4))  ifb ();

  afc_cal_sequencer #(.CNT_W(12), .SETTLE_CYC(16), .MAX_STEPS(6)) u_dut_a (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_bus (ifa)
  );

  afc_cal_sequencer #(.CNT_W(4), .SETTLE_CYC(0), .MAX_STEPS(6)) u_dut_b (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_bus (ifb)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (pv_a && !ifa.comp_valid) check("a comp_out back to idle", 32'(ifa.comp_out), 0);
      if (ifa.comp_valid) begin
        strobes_a++;
        if (qa.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL a unexpected strobe: got comp_out %b expected no strobe", ifa.comp_out);
        end else begin
          e_a = qa.pop_front();
          check("a comp_out", 32'(ifa.comp_out), 32'(e_a.code));
          if (e_a.lat >= 0) check("a latency", cyc - start_a, e_a.lat);
`ifdef AFC_SEQ_STATUS_EN
          @(posedge clk);
          #1 check("a last_cnt", 32'(ifa.last_cnt), e_a.cnt);
`endif
        end
      end
      pv_a = ifa.comp_valid;
    end else begin
      pv_a = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (pv_b && !ifb.comp_valid) check("b comp_out back to idle", 32'(ifb.comp_out), 0);
      if (ifb.comp_valid) begin
        strobes_b++;
        if (qb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL b unexpected strobe: got comp_out %b expected no strobe", ifb.comp_out);
        end else begin
          e_b = qb.pop_front();
          check("b comp_out", 32'(ifb.comp_out), 32'(e_b.code));
          if (e_b.lat >= 0) check("b latency", cyc - start_b, e_b.lat);
        end
      end
      pv_b = ifb.comp_valid;
    end else begin
      pv_b = 1'b0;
    end
  end

  task automatic push_a(input logic [2:0] code, input int lat, input int cnt);
    exp_t e;
    e.code = code; e.lat = lat; e.cnt = cnt;
    qa.push_back(e);
  endtask

  task automatic push_b(input logic [2:0] code, input int lat, input int cnt);
    exp_t e;
    e.code = code; e.lat = lat; e.cnt = cnt;
    qb.push_back(e);
  endtask

  task automatic cfg_a(input int win, input int tgt, input int tl, input logic edg);
    ifa.window_len = 16'(win);
    ifa.target_cnt = 12'(tgt);
    ifa.tol        = 12'(tl);
    ifa.vco_edge   = edg;
  endtask

  task automatic start_a_run();
    @(posedge clk);
    #1 ifa.start = 1'b1;
    start_a = cyc;
    @(posedge clk);
    #1 ifa.start = 1'b0;
  endtask

  task automatic start_b_run();
    @(posedge clk);
    #1 ifb.start = 1'b1;
    start_b = cyc;
    @(posedge clk);
    #1 ifb.start = 1'b0;
  endtask

  task automatic wait_a(input int n, input string name);
    for (int i = 0; i < 2000 && strobes_a < n; i++) @(negedge clk);
    if (strobes_a < n) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s timeout: got %0d strobes expected %0d", name, strobes_a, n);
    end
    @(posedge clk);
    #2;
  endtask

  task automatic wait_b(input int n, input string name);
    for (int i = 0; i < 2000 && strobes_b < n; i++) @(negedge clk);
    if (strobes_b < n) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s timeout: got %0d strobes expected %0d", name, strobes_b, n);
    end
    @(posedge clk);
    #2;
  endtask

  task automatic flags_a(input string name, input logic done, input logic fail);
    check({name, " cal_done"}, 32'(ifa.cal_done), 32'(done));
    check({name, " cal_fail"}, 32'(ifa.cal_fail), 32'(fail));
    check({name, " busy"}, 32'(ifa.busy), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test expected finish before 500000");
    $fatal(1);
  end

  initial begin
    ifa.start = 1'b0; ifa.abort = 1'b0;
    ifb.start = 1'b0; ifb.abort = 1'b0;
    cfg_a(101, 100, 2, 1'b1);
    ifb.window_len = 16'd20; ifb.target_cnt = 4'd10; ifb.tol = 4'd2; ifb.vco_edge = 1'b1;
    #2;
    check("reset comp_out", 32'(ifa.comp_out), 0);
    check("reset comp_valid", 32'(ifa.comp_valid), 0);
    flags_a("reset", 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // 101 edges against 100 +/- 2; includes an edge in the final window cycle.
    push_a(Freeze, 1 + 16 + 101 + 1, 101);
    start_a_run();
    wait_a(1, "run1");
    flags_a("run1", 1'b1, 1'b0);

    // 120, 90, 100 edges on successive windows.
    push_a(Fast, 1 + 16 + 120 + 1, 120);
    push_a(Slow, -1, 90);
    push_a(Freeze, -1, 100);
    cfg_a(120, 100, 2, 1'b1);
    start_a_run();
    wait_a(2, "run2 step1");
    ifa.window_len = 16'd90;
    wait_a(3, "run2 step2");
    ifa.window_len = 16'd100;
    wait_a(4, "run2 step3");
    flags_a("run2", 1'b1, 1'b0);

    // Band edges: one past the upper bound, one below the lower, then on the lower bound.
    push_a(Fast, -1, 103);
    push_a(Slow, -1, 97);
    push_a(Freeze, -1, 98);
    cfg_a(103, 100, 2, 1'b1);
    start_a_run();
    wait_a(5, "run3 step1");
    ifa.window_len = 16'd97;
    wait_a(6, "run3 step2");
    ifa.window_len = 16'd98;
    wait_a(7, "run3 step3");
    flags_a("run3", 1'b1, 1'b0);

    // No edges at all: six SLOW strobes then failure.
    for (int i = 0; i < 6; i++) push_a(Slow, (i == 0) ? 1 + 16 + 50 + 1 : -1, 0);
    cfg_a(50, 100, 2, 1'b0);
    start_a_run();
    wait_a(13, "run4");
    flags_a("run4", 1'b0, 1'b1);

    // target 1, tol 5: lower bound clamps at zero so zero edges freezes.
    push_a(Freeze, 1 + 16 + 10 + 1, 0);
    cfg_a(10, 1, 5, 1'b0);
    start_a_run();
    wait_a(14, "run5");
    flags_a("run5", 1'b1, 1'b0);

    // Changes mid-window must not affect the current measurement.
    push_a(Freeze, 1 + 16 + 40 + 1, 40);
    cfg_a(40, 40, 0, 1'b1);
    start_a_run();
    repeat (20) @(posedge clk);
    #1 ifa.window_len = 16'd10;
    ifa.target_cnt = 12'd5;
    wait_a(15, "run6");
    flags_a("run6", 1'b1, 1'b0);

    // Extra start pulses while busy are ignored.
    push_a(Freeze, 1 + 16 + 30 + 1, 30);
    cfg_a(30, 30, 1, 1'b1);
    start_a_run();
    repeat (3) @(posedge clk);
    #1 ifa.start = 1'b1;
    @(posedge clk);
    #1 ifa.start = 1'b0;
    repeat (20) @(posedge clk);
    #1 ifa.start = 1'b1;
    @(posedge clk);
    #1 ifa.start = 1'b0;
    wait_a(16, "run7");
    flags_a("run7", 1'b1, 1'b0);

    // Asynchronous reset clears a held cal_done without a clock edge.
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check("async reset cal_done", 32'(ifa.cal_done), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // abort has priority over start in idle.
    @(posedge clk);
    #1 ifa.start = 1'b1;
    ifa.abort = 1'b1;
    @(posedge clk);
    #1 ifa.start = 1'b0;
    ifa.abort = 1'b0;
    check("abort over start busy", 32'(ifa.busy), 0);

    // abort during MEASURE: back to idle, no strobe.
    cfg_a(60, 60, 1, 1'b1);
    start_a_run();
    repeat (25) @(posedge clk);
    #1 check("abort pre busy", 32'(ifa.busy), 1);
    ifa.abort = 1'b1;
    @(posedge clk);
    #1 ifa.abort = 1'b0;
    check("abort busy", 32'(ifa.busy), 0);
    repeat (120) @(posedge clk);
    #2 flags_a("abort after", 1'b0, 1'b0);

    // DUT b: CNT_W=4, saturating counter gives FAST each step, SETTLE_CYC=0 acts as one.
    for (int i = 0; i < 6; i++) push_b(Fast, (i == 0) ? 1 + 1 + 20 + 1 : -1, 15);
    start_b_run();
    wait_b(6, "b sat");
    check("b sat cal_fail", 32'(ifb.cal_fail), 1);
    check("b sat cal_done", 32'(ifb.cal_done), 0);

    // window_len 0 measures for one cycle.
    push_b(Freeze, 1 + 1 + 1 + 1, 1);
    ifb.window_len = 16'd0; ifb.target_cnt = 4'd1; ifb.tol = 4'd0;
    start_b_run();
    wait_b(7, "b win0");
    check("b win0 cal_done", 32'(ifb.cal_done), 1);

    // Reset mid-SETTLE: outputs clear at once, no strobe afterwards.
    cfg_a(20, 20, 1, 1'b1);
    start_a_run();
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("mid reset comp_out", 32'(ifa.comp_out), 0);
    check("mid reset comp_valid", 32'(ifa.comp_valid), 0);
    check("mid reset busy b", 32'(ifb.busy), 0);
    check("mid reset b cal_done", 32'(ifb.cal_done), 0);
    flags_a("mid reset", 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (200) @(posedge clk);
    #2 flags_a("post reset", 1'b0, 1'b0);

    check("a queue drained", qa.size(), 0);
    check("b queue drained", qb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
